// File: rtl/stream_packer_pkg.sv
// stream_packer_pkg
// Shared constants for the stream packer: default item width, default
// packing ratio and the lane-counter width helper.
package stream_packer_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_PACK_RATIO = 4;

  // Lane counter width for a given ratio (ratio is always >= 2 in use).
  function automatic int cnt_width(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_PACK_RATIO);

endpackage

// File: rtl/stream_packer.sv
// stream_packer
// Packs PACK_RATIO narrow items into one wide word, little-endian by lane.
// A word closes early when ilast is seen; unused upper lanes read as zero
// and okeep marks the populated lanes.
//
// Ports:
//   clk     - clock, rising edge
//   rst     - asynchronous active-high reset
//   idata   - input item
//   ivalid  - idata valid
//   ilast   - item closes a packet (qualified by ivalid)
//   iready  - packer accepts an item this cycle (depends on oready only)
//   odata   - packed word, registered
//   okeep   - lane-valid mask, registered
//   olast   - word closes a packet, registered
//   ovalid  - output word valid, registered
//   oready  - downstream accepts the word
module stream_packer
  import stream_packer_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PACK_RATIO = DEF_PACK_RATIO
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_WIDTH-1:0]            idata,
  input  logic                             ivalid,
  input  logic                             ilast,
  output logic                             iready,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] odata,
  output logic [PACK_RATIO-1:0]            okeep,
  output logic                             olast,
  output logic                             ovalid,
  input  logic                             oready
);

  localparam int CNT_W  = cnt_width(PACK_RATIO);
  localparam int WORD_W = DATA_WIDTH * PACK_RATIO;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(PACK_RATIO - 1);

  // Accumulation stage state
  logic [CNT_W-1:0]      cnt_p0, cnt_d;
  logic [WORD_W-1:0]     acc_p0, acc_d;
  // Output stage state
  logic [WORD_W-1:0]     word_p1, word_d;
  logic [PACK_RATIO-1:0] keep_p1, keep_d;
  logic                  last_p1, last_d;
  logic                  vld_p1, vld_d;

  logic in_xfer;
  logic out_xfer;
  logic word_done;

  // The output register is free when empty or being drained this cycle.
  assign iready    = ~vld_p1 | oready;
  assign in_xfer   = ivalid & iready;
  assign out_xfer  = vld_p1 & oready;
  assign word_done = in_xfer & (ilast | (cnt_p0 == LAST_LANE));

  always_comb begin
    cnt_d  = cnt_p0;
    acc_d  = acc_p0;
    word_d = word_p1;
    keep_d = keep_p1;
    last_d = last_p1;
    vld_d  = vld_p1 & ~out_xfer;

    if (in_xfer) begin
      if (word_done) begin
        // Lanes below the counter come from the accumulator, the current
        // item fills the counter lane, everything above is forced to zero
        // because the accumulator may still hold stale items there.
        for (int k = 0; k < PACK_RATIO; k++) begin
          if (CNT_W'(k) < cnt_p0) begin
            word_d[k*DATA_WIDTH +: DATA_WIDTH] = acc_p0[k*DATA_WIDTH +: DATA_WIDTH];
            keep_d[k] = 1'b1;
          end else if (CNT_W'(k) == cnt_p0) begin
            word_d[k*DATA_WIDTH +: DATA_WIDTH] = idata;
            keep_d[k] = 1'b1;
          end else begin
            word_d[k*DATA_WIDTH +: DATA_WIDTH] = '0;
            keep_d[k] = 1'b0;
          end
        end
        last_d = ilast;
        vld_d  = 1'b1;
        cnt_d  = '0;
      end else begin
        for (int k = 0; k < PACK_RATIO; k++) begin
          if (CNT_W'(k) == cnt_p0) begin
            acc_d[k*DATA_WIDTH +: DATA_WIDTH] = idata;
          end
        end
        cnt_d = cnt_p0 + CNT_W'(1);
      end
    end
  end

  // Stage boundary: accumulation (p0) and output word (p1) registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p0  <= '0;
      acc_p0  <= '0;
      word_p1 <= '0;
      keep_p1 <= '0;
      last_p1 <= 1'b0;
      vld_p1  <= 1'b0;
    end else begin
      cnt_p0  <= cnt_d;
      acc_p0  <= acc_d;
      word_p1 <= word_d;
      keep_p1 <= keep_d;
      last_p1 <= last_d;
      vld_p1  <= vld_d;
    end
  end

  assign odata  = word_p1;
  assign okeep  = keep_p1;
  assign olast  = last_p1;
  assign ovalid = vld_p1;

endmodule

// File: doc/stream_packer.md
STREAM_PACKER -- requirements
Module: stream_packer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of one input item.
REQ-002 Parameter PACK_RATIO, default 4, items per output word; legal values 2..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 idata  input  DATA_WIDTH  input item, drained from a FIFO read port.
REQ-006 ivalid  input  1  idata valid.
REQ-007 ilast  input  1  item is last of a packet; qualified by ivalid.
REQ-008 iready  output  1  packer can accept an item this cycle.
REQ-009 odata  output  DATA_WIDTH*PACK_RATIO  packed word, registered.
REQ-010 okeep  output  PACK_RATIO  lane-valid mask, bit k covers lane k, registered.
REQ-011 olast  output  1  word closes a packet, registered.
REQ-012 ovalid  output  1  output word valid, registered.
REQ-013 oready  input  1  downstream accepts the word.

Function
REQ-014 An input transfer occurs when ivalid and iready are both high in the same cycle.
REQ-015 An output transfer occurs when ovalid and oready are both high in the same cycle.
REQ-016 iready is combinational: ~ovalid | oready; it has no dependency on ivalid, idata or ilast.
REQ-017 Lane order is little-endian: the first item of a word goes to odata[DATA_WIDTH-1:0], item k to lane k.
REQ-018 A lane counter (0..PACK_RATIO-1) selects the write lane.
  - Increments on every input transfer.
  - Clears to 0 when a word completes.
REQ-019 A word completes on an input transfer when either:
  - the counter equals PACK_RATIO-1; or
  - ilast is high.
REQ-020 On completion, the output register loads in the same edge:
  - odata = accumulated lanes plus the current item, unused lanes zero;
  - okeep = lanes 0..counter set;
  - olast = ilast;
  - ovalid = 1.
REQ-021 Latency: an item completing a word on edge N makes ovalid high from edge N onward, i.e. one cycle after it was presented; no combinational input-to-output path exists except iready from oready.
REQ-022 While ovalid is high and oready is low, odata, okeep and olast remain stable and iready is low.
REQ-023 Simultaneous output transfer and word completion reload the output register with the new word; ovalid stays high.
REQ-024 An output transfer with no completion in the same cycle clears ovalid next cycle.
REQ-025 ilast on the first item of a word yields okeep with only bit 0 set and olast=1.
REQ-026 ilast on lane PACK_RATIO-1 yields okeep all ones and olast=1.
REQ-027 Accumulation register lanes above the current counter are don't-care internally but SHALL be zero on odata.
REQ-028 Sustained ivalid=1, oready=1 yields one item per cycle and one word every PACK_RATIO cycles with no bubbles.

Reset
REQ-029 rst high asynchronously forces:
  - ovalid=0, odata=0, okeep=0, olast=0;
  - counter=0, accumulation register=0.
  - Consequently iready=1.
REQ-030 Reset mid-word discards the partial word and any unconsumed output word; after release the first transfer lands in lane 0.

Structure
REQ-031 Package stream_packer_pkg holds the default DATA_WIDTH and PACK_RATIO constants and the lane-counter width, $clog2(PACK_RATIO).
REQ-032 No sub-module; single flat module with one sequential block and combinational next-state logic.

Verification
REQ-033 PACK_RATIO=4, oready=1, feed 0x11,0x22,0x33,0x44 on consecutive cycles -> one word:
  - odata=0x44332211, okeep=4'b1111, olast=0;
  - ovalid for exactly 1 cycle, the cycle after 0x44.
REQ-034 Feed 0xAA with ilast=1 as first item -> odata=0x000000AA, okeep=4'b0001, olast=1.
REQ-035 Hold oready=0 after a completed word for 5 cycles with ivalid=1:
  - iready=0 for all 5 cycles;
  - output stable;
  - no items consumed.
REQ-036 Continuous stream 0x01..0x0C, oready=1 -> three back-to-back words: 0x04030201, 0x08070605, 0x0C0B0A09; iready never low.
REQ-037 Assert rst after 2 items (0x55, 0x66), then feed 0x77,0x88,0x99,0xAA -> single word 0xAA998877; 0x55 and 0x66 never appear.
REQ-038 Random ivalid/oready at 50% for 10000 items with random ilast -> scoreboard matches every item, lane and okeep/olast; zero loss or duplication.
